counter_mod: RTL and testbench

Parametrised modulo up/down counter: the general-purpose successor to the fixed 4-bit free-running counter. It adds configurable width and modulus, a direction control, synchronous load and clear, a clock-enable prescaler, wrap or saturate mode, a terminal-count strobe and a sticky overflow flag. It is used as the shared timebase and event-counting primitive wherever the design needs a bounded counter.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_prescaler.sv | 39 +++
 rtl/counter_mod.sv | 88 ++++++++
 tb/tb_counter_mod.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter and its prescaler.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: raises step on every PRESCALE-th enabled cycle.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic step
);

  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // With PRESCALE=1, LAST is 0 and cnt_q never leaves 0, so step reduces to en.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step = en && (cnt_q == LAST);

endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with load, clear, prescaled enable,
// wrap/saturate boundary handling, terminal-count strobe and sticky overflow.
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic             SAT   = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(clr | load),
    .step   (step)
  );

  // Priority clr > load > step; a load or clear swallows a coincident step.
  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      out_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      out_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (out_q == MAX_V) begin
          out_d = SAT ? MAX_V : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          out_d = SAT ? '0 : MAX_V;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: four parameterisations share clk/rst,
// expectations are queued per target cycle and checked on the falling edge.
module tb_counter_mod;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  id;
    logic [3:0]  out;
    logic        tc;
    logic        ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en_i       [4];
  logic       dir_i      [4];
  logic       clr_i      [4];
  logic       load_i     [4];
  logic [3:0] load_val_i [4];
  logic [3:0] out_o      [4];
  logic       tc_o       [4];
  logic       ovf_o      [4];

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] cyc;
  int          checks;
  int          errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- DUT instances ----------------
  counter_mod u_def (
    .clk(clk), .rst(rst), .en(en_i[0]), .dir(dir_i[0]), .clr(clr_i[0]),
    .load(load_i[0]), .load_val(load_val_i[0]),
    .out(out_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
  );

  counter_mod #(.WIDTH(4), .MAX(9)) u_m9 (
    .clk(clk), .rst(rst), .en(en_i[1]), .dir(dir_i[1]), .clr(clr_i[1]),
    .load(load_i[1]), .load_val(load_val_i[1]),
    .out(out_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
  );

  counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en_i[2]), .dir(dir_i[2]), .clr(clr_i[2]),
    .load(load_i[2]), .load_val(load_val_i[2]),
    .out(out_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2])
  );

  counter_mod #(.WIDTH(4), .PRESCALE(3)) u_ps (
    .clk(clk), .rst(rst), .en(en_i[3]), .dir(dir_i[3]), .clr(clr_i[3]),
    .load(load_i[3]), .load_val(load_val_i[3]),
    .out(out_o[3]), .tc(tc_o[3]), .ovf(ovf_o[3])
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect (out, tc, ovf) on instance id, observed in cycle cyc+ahead.
  task automatic push(input int ahead, input int id, input int o, input bit t, input bit v);
    exp_t x;
    x.cyc = cyc + 32'(ahead);
    x.id  = 2'(id);
    x.out = 4'(o);
    x.tc  = t;
    x.ovf = v;
    exp_q.push_back(x);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_entry: id%0d due cyc %0d, now cyc %0d", e.id, e.cyc, cyc);
      end else begin
        checks++;
        if (out_o[e.id] !== e.out) begin
          errors++;
          $display("FAIL out id%0d cyc%0d: got %0d expected %0d", e.id, cyc, out_o[e.id], e.out);
        end
        checks++;
        if (tc_o[e.id] !== e.tc) begin
          errors++;
          $display("FAIL tc id%0d cyc%0d: got %b expected %b", e.id, cyc, tc_o[e.id], e.tc);
        end
        checks++;
        if (ovf_o[e.id] !== e.ovf) begin
          errors++;
          $display("FAIL ovf id%0d cyc%0d: got %b expected %b", e.id, cyc, ovf_o[e.id], e.ovf);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en_i[i]       = 1'b0;
      dir_i[i]      = 1'b1;
      clr_i[i]      = 1'b0;
      load_i[i]     = 1'b0;
      load_val_i[i] = 4'd0;
    end

    // Reset state on every instance.
    tick();
    for (int i = 0; i < 4; i++) push(0, i, 0, 1'b0, 1'b0);

    // Default instance: free count up, 12 edges after reset release.
    en_i[0]  = 1'b1;
    dir_i[0] = 1'b1;
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) push(k, 0, k, 1'b0, 1'b0);
    repeat (12) tick();
    en_i[0] = 1'b0;

    // MAX=9 wrap up: 9 -> 0 with one tc pulse, ovf sticky until clr.
    tick();
    clr_i[1] = 1'b1; en_i[1] = 1'b1; dir_i[1] = 1'b1;
    push(1, 1, 0, 1'b0, 1'b0);
    tick();
    clr_i[1] = 1'b0;
    for (int k = 1; k <= 9; k++) push(k, 1, k, 1'b0, 1'b0);
    push(10, 1, 0, 1'b1, 1'b1);
    push(11, 1, 1, 1'b0, 1'b1);
    push(12, 1, 2, 1'b0, 1'b1);
    repeat (12) tick();
    en_i[1] = 1'b0;
    push(1, 1, 2, 1'b0, 1'b1);
    tick();
    clr_i[1] = 1'b1;
    push(1, 1, 0, 1'b0, 1'b0);
    tick();
    clr_i[1] = 1'b0;

    // MAX=9 saturate down from 2: 1, 0, 0, 0 with tc on the last two steps.
    load_i[2] = 1'b1; load_val_i[2] = 4'd2; en_i[2] = 1'b1; dir_i[2] = 1'b0;
    push(1, 2, 2, 1'b0, 1'b0);
    tick();
    load_i[2] = 1'b0;
    push(1, 2, 1, 1'b0, 1'b0);
    push(2, 2, 0, 1'b0, 1'b0);
    push(3, 2, 0, 1'b1, 1'b1);
    push(4, 2, 0, 1'b1, 1'b1);
    repeat (4) tick();
    en_i[2] = 1'b0;
    push(1, 2, 0, 1'b0, 1'b1);
    tick();

    // PRESCALE=3: one step every third enabled edge; phase survives en=0.
    clr_i[3] = 1'b1; en_i[3] = 1'b1; dir_i[3] = 1'b1;
    push(1, 3, 0, 1'b0, 1'b0);
    tick();
    clr_i[3] = 1'b0;
    push(1, 3, 0, 1'b0, 1'b0);
    push(2, 3, 0, 1'b0, 1'b0);
    push(3, 3, 1, 1'b0, 1'b0);
    push(4, 3, 1, 1'b0, 1'b0);
    push(5, 3, 1, 1'b0, 1'b0);
    push(6, 3, 2, 1'b0, 1'b0);
    push(7, 3, 2, 1'b0, 1'b0);
    push(8, 3, 2, 1'b0, 1'b0);
    push(9, 3, 3, 1'b0, 1'b0);
    repeat (9) tick();
    en_i[3] = 1'b0;
    for (int k = 1; k <= 5; k++) push(k, 3, 3, 1'b0, 1'b0);
    repeat (5) tick();
    en_i[3] = 1'b1;
    push(1, 3, 3, 1'b0, 1'b0);
    tick();
    en_i[3] = 1'b0;
    push(1, 3, 3, 1'b0, 1'b0);
    push(2, 3, 3, 1'b0, 1'b0);
    repeat (2) tick();
    en_i[3] = 1'b1;
    push(1, 3, 3, 1'b0, 1'b0);
    push(2, 3, 4, 1'b0, 1'b0);
    repeat (2) tick();
    en_i[3] = 1'b0;

    // MAX=9: load clamps 14 to 9 while a step is dropped; then wrap, then clr beats load.
    load_i[1] = 1'b1; load_val_i[1] = 4'd14; en_i[1] = 1'b1; dir_i[1] = 1'b1;
    push(1, 1, 9, 1'b0, 1'b0);
    tick();
    load_i[1] = 1'b0;
    push(1, 1, 0, 1'b1, 1'b1);
    tick();
    clr_i[1] = 1'b1; load_i[1] = 1'b1;
    push(1, 1, 0, 1'b0, 1'b0);
    tick();
    clr_i[1] = 1'b0;

    // MAX=9 wrap down: load 0, then 0 -> 9 with tc, then 8.
    load_val_i[1] = 4'd0; dir_i[1] = 1'b0;
    push(1, 1, 0, 1'b0, 1'b0);
    tick();
    load_i[1] = 1'b0;
    push(1, 1, 9, 1'b1, 1'b1);
    push(2, 1, 8, 1'b0, 1'b1);
    repeat (2) tick();
    en_i[1] = 1'b0;

    // Asynchronous reset mid-count at out=7 clears outputs before the next edge.
    clr_i[0] = 1'b1; en_i[0] = 1'b1; dir_i[0] = 1'b1;
    push(1, 0, 0, 1'b0, 1'b0);
    tick();
    clr_i[0] = 1'b0;
    for (int k = 1; k <= 7; k++) push(k, 0, k, 1'b0, 1'b0);
    repeat (7) tick();
    en_i[0] = 1'b0;
    tick();
    #1;
    rst = 1'b0;
    push(0, 0, 0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // ---------------- final report ----------------
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
